// File: rtl/fifo_rd_pkg.sv
// Shared types, default sizes and helpers for the FIFO read-side checker.
package fifo_rd_pkg;

  localparam int unsigned DEF_DSIZE   = 8;
  localparam int unsigned DEF_LEN_W   = 8;
  localparam int unsigned DEF_ERR_W   = 8;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Increment that sticks at vmax; callers cast the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_checker.sv
// Read-domain FIFO consumer: pops a burst, checks it against an incrementing
// sequence and reports counts, the first mismatch, completion and timeout.
module fifo_rd_checker
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DSIZE   = DEF_DSIZE,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned ERR_W   = DEF_ERR_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [3:0]       throttle,
  input  logic [DSIZE-1:0] exp_seed,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [LEN_W-1:0] pop_count,
  output logic [ERR_W-1:0] err_count,
  output logic             err_flag,
  output logic [DSIZE-1:0] first_err_data,
  output logic [DSIZE-1:0] first_err_exp
);

  localparam int unsigned EW      = $clog2(TIMEOUT + 1);
  localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

  state_t           state, state_next;
  logic [LEN_W-1:0] remaining;
  logic [3:0]       thr;
  logic [3:0]       gap_cnt;
  logic [DSIZE-1:0] exp_data;
  logic [EW-1:0]    empty_cnt;

  // State register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and the combinational pop strobe
  always_comb begin
    state_next = state;
    rinc       = 1'b0;
    case (state)
      IDLE: if (start) state_next = (burst_len == '0) ? DONE : POP;
      POP: begin
        if (!rempty) begin
          rinc = 1'b1;
          if (remaining == LEN_W'(1)) state_next = DONE;
          else if (thr != 4'd0)       state_next = GAP;
        end else if (empty_cnt == EW'(TIMEOUT - 1)) begin
          state_next = DONE;
        end
      end
      GAP:     if (gap_cnt == 4'd1) state_next = POP;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      rinc       = 1'b0;
    end
  end

  // Datapath: counters, expected sequence and status flags
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      pop_count      <= '0;
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_data <= '0;
      first_err_exp  <= '0;
      remaining      <= '0;
      thr            <= '0;
      gap_cnt        <= '0;
      exp_data       <= '0;
      empty_cnt      <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (!abort) begin
        case (state)
          IDLE: begin
            if (start) begin
              remaining      <= burst_len;
              thr            <= throttle;
              exp_data       <= exp_seed;
              pop_count      <= '0;
              err_count      <= '0;
              err_flag       <= 1'b0;
              timeout        <= 1'b0;
              first_err_data <= '0;
              first_err_exp  <= '0;
              empty_cnt      <= '0;
              gap_cnt        <= '0;
            end
          end
          POP: begin
            if (rinc) begin
              exp_data  <= exp_data + DSIZE'(1);
              pop_count <= pop_count + LEN_W'(1);
              remaining <= remaining - LEN_W'(1);
              gap_cnt   <= thr;
              empty_cnt <= '0;
              if (rdata != exp_data) begin
                err_count <= ERR_W'(sat_inc(32'(err_count), ERR_MAX));
                if (!err_flag) begin
                  err_flag       <= 1'b1;
                  first_err_data <= rdata;
                  first_err_exp  <= exp_data;
                end
              end
            end else begin
              empty_cnt <= EW'(sat_inc(32'(empty_cnt), 32'(TIMEOUT)));
              if (empty_cnt == EW'(TIMEOUT - 1)) timeout <= 1'b1;
            end
          end
          GAP:     gap_cnt <= gap_cnt - 4'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench for fifo_rd_checker with a queue-backed FIFO model and a
// scoreboard of expected burst results compared on each done pulse.
module tb_fifo_rd_checker;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] ec;
    logic       ef;
    logic [7:0] fd;
    logic [7:0] fe;
    logic       to;
  } exp_t;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       start, abort;
  logic [7:0] burst_len;
  logic [3:0] throttle;
  logic [7:0] exp_seed;
  logic       rempty = 1'b1;
  logic [7:0] rdata  = 8'h00;
  logic       rinc, busy, done, timeout, err_flag;
  logic [7:0] pop_count, err_count, first_err_data, first_err_exp;

  logic [7:0] fifo_q[$];
  logic [7:0] model_q[$];
  exp_t       sb[$];
  int         pop_log[$];
  int         cyc = 0;
  logic       stall = 1'b0;
  logic       done_now;
  int         checks = 0;
  int         failures = 0;

  fifo_rd_checker dut (
    .rclk(rclk), .rrst_n(rrst_n), .start(start), .abort(abort),
    .burst_len(burst_len), .throttle(throttle), .exp_seed(exp_seed),
    .rempty(rempty), .rdata(rdata), .rinc(rinc), .busy(busy), .done(done),
    .timeout(timeout), .pop_count(pop_count), .err_count(err_count),
    .err_flag(err_flag), .first_err_data(first_err_data), .first_err_exp(first_err_exp)
  );

  always #5 rclk = ~rclk;

  task automatic upd();
    rempty = stall || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // FIFO model: pops on rinc at the edge, refreshes flags shortly after each edge
  always begin
    @(posedge rclk);
    cyc++;
    if (rinc) begin
      pop_log.push_back(cyc);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    #1 upd();
    @(negedge rclk);
    #1 upd();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and retire a scoreboard entry on done
  task automatic tick();
    exp_t e;
    @(negedge rclk);
    done_now = done;
    if (done) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_count",      32'(pop_count),      32'(e.pc));
        chk("err_count",      32'(err_count),      32'(e.ec));
        chk("err_flag",       32'(err_flag),       32'(e.ef));
        chk("first_err_data", 32'(first_err_data), 32'(e.fd));
        chk("first_err_exp",  32'(first_err_exp),  32'(e.fe));
        chk("timeout",        32'(timeout),        32'(e.to));
      end
    end
  endtask

  task automatic load(input logic [7:0] w);
    fifo_q.push_back(w);
    model_q.push_back(w);
  endtask

  // Build the expected burst result from the words that will be available, then start
  task automatic go(input logic [7:0] len, input logic [3:0] thr, input logic [7:0] seed,
                    input bit want_done);
    exp_t       e;
    logic [7:0] x;
    int         n;
    e = '0;
    x = seed;
    n = (model_q.size() < int'(len)) ? model_q.size() : int'(len);
    for (int i = 0; i < n; i++) begin
      if (model_q[i] !== x) begin
        if (!e.ef) begin
          e.ef = 1'b1;
          e.fd = model_q[i];
          e.fe = x;
        end
        e.ec = e.ec + 8'd1;
      end
      x = x + 8'd1;
    end
    e.pc = 8'(n);
    e.to = (model_q.size() < int'(len));
    model_q.delete();
    if (want_done) sb.push_back(e);
    pop_log.delete();
    burst_len = len; throttle = thr; exp_seed = seed; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = done_now;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    tick();
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_pops(input int k, input int budget, input string tag);
    for (int i = 0; i < budget && pop_log.size() < k; i++) tick();
    chk({tag, "_pops_reached"}, 32'(pop_log.size()), 32'(k));
  endtask

  initial begin
    int n;
    rrst_n = 1'b0; start = 1'b0; abort = 1'b0;
    burst_len = '0; throttle = '0; exp_seed = '0;
    repeat (2) @(negedge rclk);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_pop_count", 32'(pop_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_first_err", 32'({first_err_data, first_err_exp}), 32'd0);
    rrst_n = 1'b1;
    tick();

    // Back-to-back burst of matching words
    for (int i = 1; i <= 4; i++) load(8'(i));
    go(8'd4, 4'd0, 8'd1, 1'b1);
    chk("normal_busy", 32'(busy), 32'd1);
    wait_done(20, "normal");
    chk("normal_npops", 32'(pop_log.size()), 32'd4);
    for (int i = 1; i < pop_log.size(); i++) chk("normal_spacing", 32'(pop_log[i] - pop_log[i-1]), 32'd1);

    // Single corrupted word
    load(8'd1); load(8'd2); load(8'd7); load(8'd4);
    go(8'd4, 4'd0, 8'd1, 1'b1);
    wait_done(20, "mismatch");

    // Throttled pops across the data wrap
    load(8'hFE); load(8'hFF); load(8'h00);
    go(8'd3, 4'd2, 8'hFE, 1'b1);
    wait_done(30, "throttle");
    chk("throttle_npops", 32'(pop_log.size()), 32'd3);
    for (int i = 1; i < pop_log.size(); i++) chk("throttle_spacing", 32'(pop_log[i] - pop_log[i-1]), 32'd3);

    // Short empty stall mid-burst, then resume
    for (int i = 0; i < 4; i++) load(8'(8'h10 + i));
    go(8'd4, 4'd0, 8'h10, 1'b1);
    wait_pops(2, 20, "stall");
    stall = 1'b1;
    repeat (10) tick();
    chk("stall_hold_pops", 32'(pop_log.size()), 32'd2);
    chk("stall_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    wait_done(20, "stall");

    // Long empty stall ends the burst with timeout
    load(8'h20); load(8'h21);
    go(8'd5, 4'd0, 8'h20, 1'b1);
    wait_done(120, "timeout");
    chk("timeout_sticky", 32'(timeout), 32'd1);

    // Abort after two pops: no done, counts held
    for (int i = 0; i < 5; i++) load(8'(8'h30 + i));
    go(8'd5, 4'd0, 8'h30, 1'b0);
    wait_pops(2, 20, "abort");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_now) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    chk("abort_pop_count", 32'(pop_count), 32'd2);
    chk("abort_npops", 32'(pop_log.size()), 32'd2);
    fifo_q.delete();

    // Zero-length burst completes one cycle after start
    go(8'd0, 4'd0, 8'h00, 1'b1);
    chk("zero_len_done", 32'(done_now), 32'd1);
    tick();
    chk("zero_len_single", 32'(done), 32'd0);
    chk("zero_len_no_pop", 32'(pop_log.size()), 32'd0);

    // Reset asserted mid-burst with data still available
    for (int i = 1; i <= 4; i++) load(8'(i));
    go(8'd4, 4'd0, 8'd1, 1'b0);
    wait_pops(1, 20, "midrst");
    rrst_n = 1'b0;
    #1;
    chk("midrst_rempty", 32'(rempty), 32'd0);
    chk("midrst_rinc", 32'(rinc), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_pop_count", 32'(pop_count), 32'd0);
    n = pop_log.size();
    repeat (2) tick();
    chk("midrst_no_pop", 32'(pop_log.size()), 32'(n));
    chk("midrst_rinc_hold", 32'(rinc), 32'd0);
    rrst_n = 1'b1;
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_checker.md
Name: fifo_rd_checker

Overview:
Read-side consumer for the dual-clock FIFO, living entirely in the read clock domain. On a start pulse it pops a programmed number of words through the FIFO read port (rinc/rdata/rempty). It optionally inserts idle gaps between pops, and compares every popped word against an incrementing expected sequence. It reports pop and error counts, the first mismatch, and completion or timeout, for use in FIFO-level benches and on-chip self-test.

Parameters:
DSIZE, 8, FIFO data width in bits
LEN_W, 8, width of burst_len and pop_count
ERR_W, 8, width of err_count (saturating)
TIMEOUT, 64, consecutive empty cycles in POP before abandoning the burst

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a burst when idle
abort  input  1  synchronous abort; forces IDLE from any state
burst_len  input  LEN_W  words to pop; sampled on accepted start
throttle  input  4  idle cycles inserted after each pop; sampled on accepted start
exp_seed  input  DSIZE  first expected data value; sampled on accepted start
rempty  input  1  FIFO empty flag (rclk domain)
rdata  input  DSIZE  FIFO read data; valid whenever rempty=0
rinc  output  1  FIFO pop strobe
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a burst ends (normal or timeout)
timeout  output  1  sticky; set when the TIMEOUT limit is hit
pop_count  output  LEN_W  words popped in the current/last burst
err_count  output  ERR_W  mismatches in the current/last burst, saturating
err_flag  output  1  sticky; set on the first mismatch
first_err_data  output  DSIZE  rdata at the first mismatch
first_err_exp  output  DSIZE  expected value at the first mismatch

Behaviour:
- Reset (rrst_n=0, asynchronous): state=IDLE. rinc, busy, done, timeout and err_flag are 0. All counters, first_err_* and the internal exp/remaining/gap/empty counters are 0.
- Clock and reset ports: one clock (rclk), reset asynchronous active-low (rrst_n).
- States: IDLE, POP, GAP, DONE.
- IDLE, start=1:
  - burst_len, throttle and exp_seed are latched into remaining, thr and exp.
  - pop_count, err_count, err_flag, timeout and first_err_* are cleared.
  - Next state is POP, or DONE if burst_len=0.
- start outside IDLE is ignored.
- rinc = (state==POP) && !rempty && !abort. It is combinational and issues the pop in the same cycle that rdata is sampled.
- In POP, on each rinc cycle:
  - Compare rdata with exp. On a mismatch, err_count increments (saturating at 2^ERR_W-1). On the first mismatch only, capture first_err_data/first_err_exp and set err_flag.
  - exp increments, wrapping mod 2^DSIZE (0xFF -> 0x00 for DSIZE=8). pop_count and remaining are updated.
  - If remaining reaches 0, go to DONE. Else if thr!=0, go to GAP with gap counter=thr. Else stay in POP, so back-to-back pops happen every cycle.
- POP with rempty=1: the empty counter increments and no pop is issued. When the counter reaches TIMEOUT, set timeout and go to DONE. The counter clears on every pop.
- GAP: rinc=0; the gap counter decrements each cycle. The cycle in which it equals 1 transitions to POP, giving exactly thr idle cycles between pops.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high in DONE.
- abort=1: next state is IDLE from any state, no done pulse, and rinc is suppressed in that cycle. Counters and flags hold their values.
- Reset mid-burst returns everything to reset values immediately. No pop is issued while rrst_n=0.

Decomposition:
- Package fifo_rd_pkg holds:
  - state enum (IDLE, POP, GAP, DONE), 2-bit;
  - default DSIZE/LEN_W/ERR_W/TIMEOUT localparams;
  - a saturating-increment function shared by the error and empty counters.
- Single module. No sub-module is warranted; the expected-value generator is one register plus an adder.

Test Plan:
- Reset: hold rrst_n=0 mid-burst -> all outputs 0, state IDLE, rinc=0 even with rempty=0.
- Normal burst: FIFO preloaded 1..4, start with burst_len=4, throttle=0, exp_seed=1 -> rinc high 4 consecutive cycles, pop_count=4, err_count=0, one done pulse.
- Mismatch: FIFO holds 1,2,7,4, seed=1, len=4 -> err_count=1, first_err_data=7, first_err_exp=3, err_flag=1.
- Throttle and wrap: FIFO holds 0xFE,0xFF,0x00, seed=0xFE, throttle=2 -> rinc pulses spaced 3 cycles apart, err_count=0 across the wrap.
- Empty stall and timeout:
  - rempty=1 for 10 cycles mid-burst, then data arrives -> pops resume, no timeout.
  - rempty held for 64 cycles -> timeout=1, done pulse, pop_count equals words popped before the stall.
- Abort/zero length:
  - abort after 2 of 5 pops -> IDLE next cycle, no done, pop_count=2.
  - start with burst_len=0 -> done one cycle later, rinc never asserted.
